// File: rtl/equalizer_div_pkg.sv
// rtl/equalizer_div_pkg.sv - shared types and constants for the equalizer sequential divider
// Purpose: FSM state encoding, default operand widths, saturation constants and
// iteration counter width used by equalizer_div_core and equalizer_div_32s_16s_seq.
package equalizer_div_pkg;

    localparam int DIVIDEND_W = 32;
    localparam int DIVISOR_W  = 16;
    localparam int CNT_W      = 5;

    localparam logic [31:0] QMAX = 32'h7FFF_FFFF;
    localparam logic [31:0] QMIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/equalizer_div_core.sv
// rtl/equalizer_div_core.sv - one unsigned restoring shift-subtract division step
// Purpose: combinational radix-2 iteration on the {partial remainder, dividend/quotient} pair.
// Ports:
//   rem_in   - partial remainder before the step (DIVISOR_W+1 bits)
//   dq_in    - dividend bits still to be consumed, quotient bits shifted in at the LSB
//   dv       - divisor magnitude
//   rem_out  - partial remainder after the step
//   dq_out   - dq_in shifted left with the new quotient bit in the LSB
import equalizer_div_pkg::*;

module equalizer_div_core #(
    parameter int DIVIDEND_W = equalizer_div_pkg::DIVIDEND_W,
    parameter int DIVISOR_W  = equalizer_div_pkg::DIVISOR_W
) (
    input  logic [DIVISOR_W:0]    rem_in,
    input  logic [DIVIDEND_W-1:0] dq_in,
    input  logic [DIVISOR_W-1:0]  dv,
    output logic [DIVISOR_W:0]    rem_out,
    output logic [DIVIDEND_W-1:0] dq_out
);

    logic [DIVISOR_W:0] shifted;
    logic [DIVISOR_W:0] diff;
    logic               ge;

    always_comb begin
        // The remainder is always below |divisor| <= 2^(DIVISOR_W-1) between steps,
        // so its top bit is zero and dropping it in the shift loses nothing.
        shifted = {rem_in[DIVISOR_W-1:0], dq_in[DIVIDEND_W-1]};
        diff    = shifted - {1'b0, dv};
        ge      = (shifted >= {1'b0, dv});
        rem_out = ge ? diff : shifted;
        dq_out  = {dq_in[DIVIDEND_W-2:0], ge};
    end

endmodule

// File: rtl/equalizer_div_32s_16s_seq.sv
// rtl/equalizer_div_32s_16s_seq.sv - fixed-latency 32s/16s truncating sequential divider
// Purpose: iterative signed divider with start/done handshake, 33 enabled edges from
// acceptance to registered result, saturating on divide-by-zero and -2^31/-1.
// Ports:
//   clk, reset     - rising-edge clock, synchronous active-high reset
//   ce             - clock enable; all state and outputs hold while low
//   start          - operand strobe, taken when ready=1 and ce=1
//   dividend       - signed 32-bit dividend, captured on the accepting edge
//   divisor        - signed 16-bit divisor, captured on the accepting edge
//   ready          - high while idle
//   done           - result strobe, one enabled cycle
//   quotient       - signed quotient (truncated toward zero), held until the next result
//   remainder      - signed remainder with the dividend's sign
//   div_zero       - divisor was zero for the current result
//   overflow       - current result was -2^31 / -1
import equalizer_div_pkg::*;

module equalizer_div_32s_16s_seq #(
    parameter int DIVIDEND_W = equalizer_div_pkg::DIVIDEND_W,
    parameter int DIVISOR_W  = equalizer_div_pkg::DIVISOR_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         start,
    input  logic signed [DIVIDEND_W-1:0] dividend,
    input  logic signed [DIVISOR_W-1:0]  divisor,
    output logic                         ready,
    output logic                         done,
    output logic signed [DIVIDEND_W-1:0] quotient,
    output logic signed [DIVISOR_W-1:0]  remainder,
    output logic                         div_zero,
    output logic                         overflow
);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [DIVISOR_W:0]      rem;
    logic [DIVIDEND_W-1:0]   dq;
    logic [DIVISOR_W-1:0]    abs_dv;
    logic                    neg_dd;
    logic                    neg_dv;

    logic [DIVISOR_W:0]      rem_nxt;
    logic [DIVIDEND_W-1:0]   dq_nxt;

    logic [DIVIDEND_W-1:0]   abs_dd_in;
    logic [DIVISOR_W-1:0]    abs_dv_in;
    logic                    dv_is_zero;
    logic                    is_ovf;
    logic [DIVIDEND_W-1:0]   q_fix;
    logic [DIVISOR_W-1:0]    r_fix;

    equalizer_div_core #(
        .DIVIDEND_W (DIVIDEND_W),
        .DIVISOR_W  (DIVISOR_W)
    ) u_core (
        .rem_in  (rem),
        .dq_in   (dq),
        .dv      (abs_dv),
        .rem_out (rem_nxt),
        .dq_out  (dq_nxt)
    );

    always_comb begin
        // Two's-complement negation maps the most negative value onto itself,
        // which is exactly its unsigned magnitude.
        abs_dd_in  = dividend[DIVIDEND_W-1] ? DIVIDEND_W'(-dividend) : DIVIDEND_W'(dividend);
        abs_dv_in  = divisor[DIVISOR_W-1]   ? DIVISOR_W'(-divisor)   : DIVISOR_W'(divisor);

        dv_is_zero = (abs_dv == '0);
        // At FIX, dq holds the quotient magnitude; magnitude 2^31 with |divisor|=1
        // only happens for |dividend| = 2^31, and both signs negative makes it +2^31.
        is_ovf     = neg_dd && neg_dv && (abs_dv == DIVISOR_W'(1)) && (dq == QMIN);

        q_fix = '0;
        r_fix = '0;
        if (dv_is_zero) begin
            q_fix = neg_dd ? QMIN : QMAX;
        end else if (is_ovf) begin
            q_fix = QMAX;
        end else begin
            q_fix = (neg_dd ^ neg_dv) ? -dq : dq;
            r_fix = neg_dd ? -rem[DIVISOR_W-1:0] : rem[DIVISOR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            dq        <= '0;
            abs_dv    <= '0;
            neg_dd    <= 1'b0;
            neg_dv    <= 1'b0;
            ready     <= 1'b1;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        neg_dd <= dividend[DIVIDEND_W-1];
                        neg_dv <= divisor[DIVISOR_W-1];
                        dq     <= abs_dd_in;
                        abs_dv <= abs_dv_in;
                        rem    <= '0;
                        cnt    <= CNT_W'(DIVIDEND_W - 1);
                        ready  <= 1'b0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    dq  <= dq_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                    div_zero  <= dv_is_zero;
                    overflow  <= is_ovf && !dv_is_zero;
                    done      <= 1'b1;
                    ready     <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_equalizer_div_32s_16s_seq.sv
// tb/tb_equalizer_div_32s_16s_seq.sv - self-checking bench for equalizer_div_32s_16s_seq
module tb_equalizer_div_32s_16s_seq;

    typedef struct packed {
        logic [31:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
    } res_t;

    logic               clk;
    logic               reset;
    logic               ce;
    logic               start;
    logic signed [31:0] dividend;
    logic signed [15:0] divisor;
    logic               ready;
    logic               done;
    logic signed [31:0] quotient;
    logic signed [15:0] remainder;
    logic               div_zero;
    logic               overflow;

    int checks   = 0;
    int failures = 0;
    int fail_prints = 0;

    bit ce_rand = 0;

    // Behavioural model state: edges remaining until the result appears.
    int          m_left = 0;
    bit          m_init = 0;
    bit          m_done = 0;
    res_t        m_res  = '0;
    logic [31:0] p_dd;
    logic [15:0] p_dv;
    int          m_acc_cnt = 0;

    equalizer_div_32s_16s_seq dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t ref_div(input logic [31:0] a_bits, input logic [15:0] b_bits);
        res_t   t;
        longint la;
        longint lb;
        la = longint'($signed(a_bits));
        lb = longint'($signed(b_bits));
        t  = '0;
        if (lb == 0) begin
            t.q  = (la >= 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            t.dz = 1'b1;
        end else if (la == -64'sd2147483648 && lb == -64'sd1) begin
            t.q  = 32'h7FFF_FFFF;
            t.ov = 1'b1;
        end else begin
            t.q = 32'(la / lb);
            t.r = 16'(la % lb);
        end
        return t;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_init = 1;
            m_left = 0;
            m_done = 0;
            m_res  = '0;
        end else if (ce) begin
            m_done = 0;
            if (m_left == 0) begin
                if (start) begin
                    p_dd      = dividend;
                    p_dv      = divisor;
                    m_left    = 33;
                    m_acc_cnt = m_acc_cnt + 1;
                end
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_res  = ref_div(p_dd, p_dv);
                    m_done = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            checks = checks + 1;
            if (ready !== (m_left == 0) || done !== m_done || quotient !== m_res.q ||
                remainder !== m_res.r || div_zero !== m_res.dz || overflow !== m_res.ov) begin
                failures = failures + 1;
                if (fail_prints < 20) begin
                    fail_prints = fail_prints + 1;
                    $display("FAIL cycle_compare t=%0t got rdy=%b done=%b q=%h r=%h dz=%b ov=%b want rdy=%b done=%b q=%h r=%h dz=%b ov=%b",
                             $time, ready, done, quotient, remainder, div_zero, overflow,
                             (m_left == 0), m_done, m_res.q, m_res.r, m_res.dz, m_res.ov);
                end
            end
        end
    end

    task automatic check_int(input string name, input longint act, input longint exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic check_res(input string name, input logic [31:0] q, input logic [15:0] r,
                             input logic dz, input logic ov);
        checks = checks + 1;
        if (quotient !== q || remainder !== r || div_zero !== dz || overflow !== ov) begin
            failures = failures + 1;
            $display("FAIL %s got q=%h r=%h dz=%b ov=%b want q=%h r=%h dz=%b ov=%b",
                     name, quotient, remainder, div_zero, overflow, q, r, dz, ov);
        end
    endtask

    task automatic step();
        @(negedge clk);
        ce = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    // Presents an operation from the current negedge, returns at the first negedge
    // where done is seen. lat counts enabled edges after acceptance.
    task automatic do_div(input logic [31:0] a, input logic [15:0] b,
                          output int lat, output int acc_edges);
        int pre;
        int guard;
        int k;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        acc_edges = 0;
        lat       = 0;
        pre       = m_acc_cnt;
        guard     = 0;
        while (m_acc_cnt == pre && guard < 200) begin
            if (ce) acc_edges = acc_edges + 1;
            step();
            guard = guard + 1;
        end
        k = 0;
        guard = 0;
        // Junk operands with start held for a few busy cycles must be ignored.
        while (done !== 1'b1 && guard < 3000) begin
            if (k < 3) begin
                start    = 1'b1;
                dividend = $urandom;
                divisor  = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            if (ce) lat = lat + 1;
            step();
            k = k + 1;
            guard = guard + 1;
        end
        start = 1'b0;
        if (done !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL done_timeout got=no_done want=done");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int acc;
        logic [31:0] ra;
        logic [15:0] rb;
        res_t t;

        reset    = 1'b1;
        ce       = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        t = ref_div(32'd1000, 16'd7);
        check_int("model_1000_7_q", longint'($signed(t.q)), 142);
        check_int("model_1000_7_r", longint'($signed(t.r)), 6);
        t = ref_div(-32'sd1000, 16'd7);
        check_int("model_m1000_7_r", longint'($signed(t.r)), -6);
        t = ref_div(32'd1000, -16'sd7);
        check_int("model_1000_m7_q", longint'($signed(t.q)), -142);

        repeat (3) step();
        check_res("reset_state", 32'h0, 16'h0, 1'b0, 1'b0);
        check_int("reset_ready", ready, 1);
        check_int("reset_done", done, 0);
        reset = 1'b0;

        do_div(32'd1000, 16'd7, lat, acc);
        check_res("div_1000_7", 32'd142, 16'd6, 1'b0, 1'b0);
        check_int("lat_1000_7", lat, 33);
        do_div(-32'sd1000, 16'd7, lat, acc);
        check_res("div_m1000_7", -32'sd142, -16'sd6, 1'b0, 1'b0);
        do_div(32'd1000, -16'sd7, lat, acc);
        check_res("div_1000_m7", -32'sd142, 16'd6, 1'b0, 1'b0);
        do_div(32'h8000_0000, 16'hFFFF, lat, acc);
        check_res("div_ovf", 32'h7FFF_FFFF, 16'h0, 1'b0, 1'b1);
        do_div(32'h8000_0000, 16'h8000, lat, acc);
        check_res("div_min_min16", 32'd65536, 16'h0, 1'b0, 1'b0);
        do_div(32'd12345, 16'd0, lat, acc);
        check_res("div_pos_zero", 32'h7FFF_FFFF, 16'h0, 1'b1, 1'b0);
        check_int("lat_div_zero", lat, 33);
        // Back-to-back: next call presents start during the done cycle.
        do_div(-32'sd5, 16'd0, lat, acc);
        check_res("div_neg_zero", 32'h8000_0000, 16'h0, 1'b1, 1'b0);
        check_int("b2b_accept_edges", acc, 1);

        // Reset during CALC iteration 10.
        dividend = 32'd1000;
        divisor  = 16'd7;
        start    = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_int("midcalc_reset_ready", ready, 1);
        check_int("midcalc_reset_done", done, 0);
        check_res("midcalc_reset_outs", 32'h0, 16'h0, 1'b0, 1'b0);
        do_div(32'd100, 16'd3, lat, acc);
        check_res("div_100_3", 32'd33, 16'd1, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ce_rand = (i >= 15);
            case ($urandom_range(0, 3))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'($signed(16'($urandom)));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 16'h0000;
                1:       rb = 16'h0001;
                2:       rb = 16'hFFFF;
                3:       rb = 16'h8000;
                4:       rb = 16'($urandom_range(1, 20));
                default: rb = 16'($urandom);
            endcase
            do_div(ra, rb, lat, acc);
            t = ref_div(ra, rb);
            check_res("rand_result", t.q, t.r, t.dz, t.ov);
            check_int("rand_latency", lat, 33);
            check_int("rand_accept_edges", acc, 1);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 4)) step();
            end
        end
        ce_rand = 0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/equalizer_div_32s_16s_seq.md
# equalizer_div_32s_16s_seq

Sequential signed divider for the equalizer datapath: divides a 32-bit signed dividend (typically a 32-bit product from the 16×16 channel-gain multiplier) by a 16-bit signed divisor (channel estimate). It returns a truncated 32-bit signed quotient and a 16-bit signed remainder. The divider is the inverse of the pipelined product path and sits after it in the equalizer. It is an iterative radix-2 engine with a start/done handshake and constant latency, so the HLS schedule can treat it as a fixed-latency operator.

## Interface
- DIVIDEND_W, 32, dividend and quotient width.
- DIVISOR_W, 16, divisor and remainder width.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  clock enable. When low, all state and outputs hold.
- start  in  1  operand-valid strobe. Sampled only when ready=1 and ce=1.
- dividend  in  DIVIDEND_W  signed dividend. Captured on the accepting edge.
- divisor  in  DIVISOR_W  signed divisor. Captured on the accepting edge.
- ready  out  1  high in IDLE. Reset value 1.
- done  out  1  one-cycle result strobe. Reset value 0.
- quotient  out  DIVIDEND_W  signed quotient. Reset value 0. Held until the next FIX.
- remainder  out  DIVISOR_W  signed remainder. Reset value 0. Held until the next FIX.
- div_zero  out  1  divisor was 0. Reset value 0. Updated with quotient.
- overflow  out  1  the operation was −2^31 / −1. Reset value 0. Updated with quotient.

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - ready=1.
  - start accepted: latch the operand signs, |dividend| (32-bit unsigned; −2^31 → 0x80000000) and |divisor| (16-bit unsigned; −32768 → 0x8000).
  - Clear the partial remainder (17 bits). Load iteration counter = 31. Go to CALC.
- CALC, each ce edge:
  - Shift {rem, dq} left by 1.
  - If rem ≥ |divisor|, subtract |divisor| and set the quotient LSB.
  - Decrement the counter. After the counter=0 iteration, go to FIX.
- FIX:
  - Negate the quotient when the signs differ. The remainder takes the dividend's sign (truncation toward zero; remainder magnitude < |divisor|, so it fits in 16 bits).
  - Register the outputs, pulse done, return to IDLE.
- Divisor = 0:
  - The iteration still runs, for constant latency.
  - FIX outputs quotient 0x7FFFFFFF if dividend ≥ 0, else 0x80000000. Remainder 0, div_zero=1.
- Overflow, −2^31 / −1: quotient 0x7FFFFFFF, remainder 0, overflow=1.
- start while not ready is ignored, with no queuing. Operand changes during CALC have no effect.
- reset at any point, including mid-CALC: return to IDLE and apply all reset values on that edge. The partial result is discarded.

## Timing
- start accepted at edge N.
- CALC at edges N+1..N+32.
- FIX at edge N+33: the outputs update, done=1 and ready=1 during cycle N+33→N+34.
- Latency is 33 enabled edges from acceptance to outputs valid. Throughput is one division per 34 enabled edges.
- done clears on the next ce edge. A start presented in the done cycle is accepted on that same edge (back-to-back).
- ce low stretches every phase exactly. done stays high while ce is low.

## Structure
- Shared package equalizer_div_pkg:
  - state enum {IDLE, CALC, FIX}.
  - DIVIDEND_W and DIVISOR_W defaults.
  - Saturation constants QMAX=32'h7FFFFFFF and QMIN=32'h80000000.
  - Counter width 5.
- Sub-module equalizer_div_core: the unsigned shift-subtract step, one iteration, combinational. It holds the 17-bit compare/subtract.
- The top level holds the FSM, the sign handling and the output registers.

## Test plan
- 1000 / 7 → quotient 142, remainder 6, done at enabled edge N+33, flags 0.
- −1000 / 7 → quotient −142, remainder −6. 1000 / −7 → quotient −142, remainder 6.
- −2147483648 / −1 → quotient 0x7FFFFFFF, overflow=1. −2147483648 / −32768 → quotient 65536, remainder 0.
- 12345 / 0 → quotient 0x7FFFFFFF, div_zero=1. −5 / 0 → quotient 0x80000000, div_zero=1. Latency unchanged.
- Back-to-back starts: the second start is asserted in the done cycle and is accepted. ce toggled randomly → same results, with latency in enabled edges unchanged.
- reset asserted at CALC iteration 10 → next edge ready=1, done=0, outputs 0. A fresh 100 / 3 then yields 33 remainder 1.
